// File: rtl/btn_debounce_pulse_pkg.sv
// Shared FSM encodings and default timing constants for the push-button front end.
package btn_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_DB_PRESS   = 2'b01,
    ST_PRESSED    = 2'b10,
    ST_DB_RELEASE = 2'b11
  } state_e;

  // 10 ms debounce and 100 ms repeat at 50 MHz
  localparam int unsigned DB_CYCLES_50M     = 500_000;
  localparam int unsigned REPEAT_CYCLES_50M = 5_000_000;
  localparam int unsigned CNT_W_50M         = 23;

  // Short values for simulation
  localparam int unsigned DB_CYCLES_SIM     = 4;
  localparam int unsigned REPEAT_CYCLES_SIM = 10;
  localparam int unsigned CNT_W_SIM         = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Synchronises and debounces one push button, emitting a one-cycle pulse per
// accepted press plus optional auto-repeat pulses while the button is held.
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_50M,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_50M,
  parameter int unsigned CNT_W         = CNT_W_50M
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic [1:0] state_dbg
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             btn_s;
  state_e           state, state_nxt;
  logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
  logic             level_nxt, pulse_nxt;
  logic             db_done, rep_done;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  assign db_done  = (db_cnt == DB_LAST);
  assign rep_done = (rep_cnt == REP_LAST);

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      db_cnt  <= '0;
      rep_cnt <= '0;
    end else begin
      state   <= state_nxt;
      db_cnt  <= db_cnt_nxt;
      rep_cnt <= rep_cnt_nxt;
    end
  end

  // Next state; counters stop at their terminal value and are reloaded on transition
  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    rep_cnt_nxt = rep_cnt;
    unique case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_nxt  = ST_DB_PRESS;
          db_cnt_nxt = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
        end else if (db_done) begin
          state_nxt   = ST_PRESSED;
          rep_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_nxt  = ST_DB_RELEASE;
          db_cnt_nxt = '0;
        end else if (REPEAT_EN) begin
          rep_cnt_nxt = rep_done ? '0 : rep_cnt + CNT_W'(1);
        end
      end
      ST_DB_RELEASE: begin
        if (btn_s) begin
          state_nxt   = ST_PRESSED;
          rep_cnt_nxt = '0;
        end else if (db_done) begin
          state_nxt = ST_IDLE;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs
  always_comb begin
    level_nxt = btn_level;
    pulse_nxt = 1'b0;
    unique case (state)
      ST_DB_PRESS: begin
        if (btn_s && db_done) begin
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (btn_s && REPEAT_EN && rep_done) begin
          pulse_nxt = 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        if (!btn_s && db_done) begin
          level_nxt = 1'b0;
        end
      end
      default: begin
        level_nxt = btn_level;
        pulse_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      btn_level <= level_nxt;
      btn_pulse <= pulse_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench: expected pulse cycles are queued by the stimulus and matched by a monitor.
module tb_btn_debounce_pulse;
  import btn_debounce_pulse_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw0, raw1;
  logic       lvl0, pls0, lvl1, pls1;
  logic [1:0] st0, st1;
  int         cyc = 0;
  int         cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         q0[$];
  int         q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter enabled by the non-repeating instance
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (pls1) cnt <= cnt + 1;
  end

  btn_debounce_pulse #(
    .DB_CYCLES(DB_CYCLES_SIM), .REPEAT_EN(1'b1),
    .REPEAT_CYCLES(REPEAT_CYCLES_SIM), .CNT_W(CNT_W_SIM)
  ) dut_rep (
    .clk(clk), .rst(rst), .btn_raw(raw0),
    .btn_level(lvl0), .btn_pulse(pls0), .state_dbg(st0)
  );

  btn_debounce_pulse #(
    .DB_CYCLES(DB_CYCLES_SIM), .REPEAT_EN(1'b0),
    .REPEAT_CYCLES(REPEAT_CYCLES_SIM), .CNT_W(CNT_W_SIM)
  ) dut_one (
    .clk(clk), .rst(rst), .btn_raw(raw1),
    .btn_level(lvl1), .btn_pulse(pls1), .state_dbg(st1)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drained(input string nm);
    check({nm, "_missing_pulses_rep"}, q0.size(), 0);
    check({nm, "_missing_pulses_one"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  task automatic pop_cmp(input string nm, inout int q[$]);
    int exp;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: pulse at cycle %0d, no pulse expected", nm, cyc);
    end else begin
      exp = q.pop_front();
      if (exp != cyc) begin
        n_fail++;
        $display("FAIL %s: pulse at cycle %0d, expected at cycle %0d", nm, cyc, exp);
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (pls0) pop_cmp("pulse_rep", q0);
      if (pls1) pop_cmp("pulse_one", q1);
    end
  endtask

  initial begin
    int t, u, s;
    rst  = 1'b1;
    raw0 = 1'b1;
    raw1 = 1'b1;
    fork
      monitor();
    join_none

    // 1: reset with button held, then the first accepted press
    repeat (3) @(negedge clk);
    check("rst_level_rep", int'(lvl0), 0);
    check("rst_pulse_rep", int'(pls0), 0);
    check("rst_state_rep", int'(st0), 0);
    check("rst_level_one", int'(lvl1), 0);
    check("rst_pulse_one", int'(pls1), 0);
    check("rst_state_one", int'(st1), 0);
    t = cyc;
    q0.push_back(t + 7);
    q0.push_back(t + 17);
    q0.push_back(t + 27);
    q1.push_back(t + 7);
    rst = 1'b0;
    goto(t + 6);
    check("t1_level_before_rep", int'(lvl0), 0);
    check("t1_level_before_one", int'(lvl1), 0);
    goto(t + 7);
    check("t1_level_after_rep", int'(lvl0), 1);
    check("t1_level_after_one", int'(lvl1), 1);
    check("t1_state_pressed", int'(st0), 2);

    // 2: held 30 cycles, repeat pulses only on the repeating instance
    goto(t + 30);
    raw0 = 1'b0;
    raw1 = 1'b0;
    u = cyc;
    goto(u + 6);
    check("t2_release_level_hold", int'(lvl0), 1);
    goto(u + 7);
    check("t2_release_level_rep", int'(lvl0), 0);
    check("t2_release_level_one", int'(lvl1), 0);
    check("t2_release_state", int'(st0), 0);
    goto(u + 12);
    drained("t2");

    // 3: bouncing press, then stable high
    t = cyc;
    s = t + 8;
    q1.push_back(s + 7);
    for (int k = 0; k < 15; k++) begin
      goto(t + k);
      if (k == 0 || k == 4 || k == 8) raw1 = 1'b1;
      if (k == 2 || k == 6) raw1 = 1'b0;
      check("t3_level_no_glitch", int'(lvl1), 0);
    end
    goto(s + 7);
    check("t3_level_accept", int'(lvl1), 1);
    goto(s + 20);
    check("t3_level_held", int'(lvl1), 1);
    raw1 = 1'b0;
    u = cyc;
    goto(u + 7);
    check("t3_level_release", int'(lvl1), 0);
    goto(u + 10);
    drained("t3");

    // 4: glitch shorter than the debounce window
    t = cyc;
    raw1 = 1'b1;
    goto(t + 3);
    raw1 = 1'b0;
    goto(t + 4);
    check("t4_state_db_press", int'(st1), 1);
    goto(t + 12);
    check("t4_level", int'(lvl1), 0);
    check("t4_state_idle", int'(st1), 0);
    drained("t4");

    // 5: short dropout while pressed, then a real release
    t = cyc;
    raw1 = 1'b1;
    q1.push_back(t + 7);
    goto(t + 12);
    check("t5_level_pressed", int'(lvl1), 1);
    u = cyc;
    raw1 = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      goto(u + k);
      if (k == 2) raw1 = 1'b1;
      if (k == 3) check("t5_state_db_release", int'(st1), 3);
      if (k == 5) check("t5_state_back_pressed", int'(st1), 2);
      check("t5_level_dropout", int'(lvl1), 1);
    end
    u = cyc;
    raw1 = 1'b0;
    goto(u + 3);
    check("t5_state_release", int'(st1), 3);
    goto(u + 6);
    check("t5_level_hold", int'(lvl1), 1);
    goto(u + 7);
    check("t5_level_released", int'(lvl1), 0);
    check("t5_state_idle", int'(st1), 0);
    goto(u + 12);
    drained("t5");

    // 6: pulses drive a counter; reset in mid-press clears everything
    rst = 1'b1;
    @(negedge clk);
    check("t6_cnt_reset", cnt, 0);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      t = cyc;
      raw1 = 1'b1;
      q1.push_back(t + 7);
      goto(t + 10);
      raw1 = 1'b0;
      goto(t + 22);
    end
    check("t6_cnt_three", cnt, 3);
    t = cyc;
    raw1 = 1'b1;
    q1.push_back(t + 7);
    goto(t + 9);
    check("t6_cnt_four", cnt, 4);
    check("t6_level_before_rst", int'(lvl1), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_cnt_cleared", cnt, 0);
    check("t6_level_cleared", int'(lvl1), 0);
    check("t6_state_cleared", int'(st1), 0);
    check("t6_pulse_cleared", int'(pls1), 0);
    @(negedge clk);
    t = cyc;
    q1.push_back(t + 7);
    rst = 1'b0;
    goto(t + 6);
    check("t6_level_rerun_before", int'(lvl1), 0);
    goto(t + 8);
    check("t6_cnt_after_rerun", cnt, 1);
    check("t6_level_after_rerun", int'(lvl1), 1);
    raw1 = 1'b0;
    goto(t + 20);
    check("t6_level_final", int'(lvl1), 0);
    drained("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
